// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU-side read/status bus of the UART receiver
interface uart_rx_fifo_if #(parameter int DEPTH = 4);
  logic                   rd_en;
  logic                   clr_err;
  logic [7:0]             rd_data;
  logic                   rd_valid;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  logic                   frame_err;
  logic                   overrun;
  modport master(output rd_en, clr_err, input rd_data, rd_valid, count, busy, frame_err, overrun);
  modport slave(input rd_en, clr_err, output rd_data, rd_valid, count, busy, frame_err, overrun);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with start/stop validation feeding a show-ahead FIFO
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 215,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic resetn,
  input logic RXD,
  uart_rx_fifo_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, nxt;
  logic [1:0] sync;
  logic rx_s, half_hit, last_hit, cnt_clr, sample, push, frame_set, pop, wr, full;
  logic frame_err, overrun;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] count;
  assign rx_s = sync[1];
  assign half_hit = cnt == HALF;
  assign last_hit = cnt == LAST;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync <= 2'b11;
    else sync <= {sync[0], RXD};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (!rx_s) nxt = START;
      START:     if (half_hit) nxt = rx_s ? IDLE : DATA;
      DATA:      if (last_hit && idx == 3'd7) nxt = STOP;
      STOP:      if (last_hit) nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state != IDLE;
    cnt_clr = state == IDLE || state == WAIT_HIGH || (state == START && half_hit) || last_hit;
    sample = state == DATA && last_hit;
    push = state == STOP && last_hit && rx_s;
    frame_set = state == STOP && last_hit && !rx_s;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state == START) idx <= '0;
      else if (sample) idx <= idx + 3'd1;
      if (sample) shreg[idx] <= rx_s;
    end
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign pop = bus.rd_en && bus.rd_valid;
  assign full = count == (AW + 1)'(DEPTH);
  assign wr = push && (!full || pop);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rp <= '0;
      wp <= '0;
      count <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= shreg;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      frame_err <= bus.clr_err ? 1'b0 : frame_err | frame_set;
      overrun <= bus.clr_err ? 1'b0 : overrun | (push && full && !pop);
    end
  assign bus.rd_valid = count != '0;
  assign bus.rd_data = bus.rd_valid ? mem[rp] : '0;
  assign bus.count = count;
  assign bus.frame_err = frame_err;
  assign bus.overrun = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed frames checked against a byte-queue model
module tb_uart_rx_fifo;
  localparam int CPB = 215;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rxd = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic m_ovr = 1'b0;
  logic m_ferr = 1'b0;
  logic [7:0] b;
  logic [7:0] list_a [4] = '{8'h35, 8'h37, 8'h38, 8'h0A};
  logic [7:0] list_b [4] = '{8'h31, 8'h32, 8'h33, 8'h30};
  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus();
  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut(.clk(clk), .resetn(resetn), .RXD(rxd), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input int stretch = 0, input logic stop = 1'b1);
    rxd = 1'b0;
    tick(CPB + stretch);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
  endtask
  function automatic void model_rx(input logic [7:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else m_ovr = 1'b1;
  endfunction
  task automatic check_all(input string tag);
    logic [7:0] head;
    head = q.size() != 0 ? q[0] : 8'h00;
    check({tag, "_count"}, 32'(bus.count), q.size());
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'(q.size() != 0));
    check({tag, "_data"}, 32'(bus.rd_data), 32'(head));
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
  endtask
  task automatic pop();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  task automatic drain(input string tag);
    while (q.size() != 0) begin
      check({tag, "_order"}, 32'(bus.rd_data), 32'(q[0]));
      pop();
    end
    check_all({tag, "_empty"});
  endtask
  task automatic clr();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    check_all("reset");
    check("reset_busy", 32'(bus.busy), 0);
    resetn = 1'b1;
    tick(5);
    send(8'h35, 10);
    model_rx(8'h35);
    check_all("single");
    check("single_busy", 32'(bus.busy), 0);
    pop();
    check_all("single_pop");
    foreach (list_a[i]) begin
      send(list_a[i]);
      model_rx(list_a[i]);
    end
    check_all("fill");
    send(8'h31);
    model_rx(8'h31);
    check_all("overrun");
    drain("fill");
    clr();
    check_all("clr_ovr");
    rxd = 1'b0;
    tick(40);
    check("glitch_busy", 32'(bus.busy), 1);
    tick(10);
    rxd = 1'b1;
    tick(CPB);
    check("glitch_idle", 32'(bus.busy), 0);
    check_all("glitch");
    send(8'h55, 0, 1'b0);
    m_ferr = 1'b1;
    check_all("ferr");
    check("ferr_busy", 32'(bus.busy), 1);
    tick(2 * CPB);
    check("break_busy", 32'(bus.busy), 1);
    check_all("break");
    rxd = 1'b1;
    tick(4);
    check("break_idle", 32'(bus.busy), 0);
    clr();
    check_all("clr_ferr");
    foreach (list_b[i]) begin
      send(list_b[i]);
      model_rx(list_b[i]);
    end
    check_all("full");
    fork
      send(8'h34);
      begin
        int k = 0;
        while (!bus.busy && k < 20) begin
          tick(1);
          k++;
        end
        check("fp_start", 32'(bus.busy), 1);
        tick(CPB / 2 + 9 * CPB - 1);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'h34);
    check_all("fullpop");
    drain("fullpop");
    send(8'h11);
    model_rx(8'h11);
    check_all("pre_rst");
    b = 8'hA5;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = b[4];
    tick(100);
    resetn = 1'b0;
    #1;
    q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    check_all("midrst");
    check("midrst_busy", 32'(bus.busy), 0);
    rxd = 1'b1;
    @(negedge clk);
    tick(4);
    resetn = 1'b1;
    tick(CPB);
    send(8'h0A);
    model_rx(8'h0A);
    check_all("after_rst");
    drain("after_rst");
    for (int i = 0; i < 10; i++) begin
      send(8'(i));
      model_rx(8'(i));
      check_all("wrap");
      check("wrap_le1", 32'(bus.count <= 1), 1);
      pop();
      check_all("wrap_pop");
    end
    repeat (8) begin
      b = 8'($urandom);
      send(b, $urandom_range(0, 10));
      model_rx(b);
      check_all("rnd");
      repeat ($urandom_range(0, 1)) begin
        check("rnd_order", 32'(bus.rd_data), 32'(q.size() != 0 ? q[0] : 8'h00));
        pop();
      end
    end
    drain("rnd");
    clr();
    check_all("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the SOC's UART: recovers 8N1 frames from the `RXD` pin, validates start and stop bits, and buffers received bytes in a small FIFO for the CPU's memory-mapped UART read path. It is the receiving end of the byte-serialising stimulus the system bench drives onto `RXD`. It sits between the pad and the IO register decode, alongside the existing transmitter on `TXD`.

## Interface
- `CLKS_PER_BIT`, 215: clock cycles per bit. The default gives 46.5 kbaud at 10 MHz (215 × 100 ns = 21.5 µs). Legal range ≥ 8.
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock; everything is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `RXD`  in  1  serial line; idles high; asynchronous to `clk`.
- `rd_en`  in  1  pops the head entry when `rd_valid`=1; ignored when the FIFO is empty.
- `clr_err`  in  1  clears `frame_err` and `overrun`.
- `rd_data`  out  8  head of FIFO (show-ahead); 0 when empty.
- `rd_valid`  out  1  FIFO not empty.
- `count`  out  $clog2(DEPTH)+1  number of entries held.
- `busy`  out  1  receive FSM is not in IDLE.
- `frame_err`  out  1  sticky; set when a stop bit is sampled low.
- `overrun`  out  1  sticky; set when a byte completes while the FIFO is full.

## Operation
- **Synchroniser:** `RXD` passes through a 2-flop synchroniser, giving `rx_s`. The synchronisers reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **Bit counter:** `cnt` runs 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT). Bit index `idx` runs 0..7.
- **IDLE:** when `rx_s`=0, go to START with `cnt`=0.
- **START:** when `cnt`=CLKS_PER_BIT/2-1 (integer division), check `rx_s`.
  - `rx_s`=0: go to DATA, `cnt`=0, `idx`=0.
  - `rx_s`=1: treat as a glitch and return to IDLE. Nothing is pushed and no flag is set.
- **DATA:** when `cnt`=CLKS_PER_BIT-1, store `rx_s` into `shreg[idx]` (LSB first) and reset `cnt` to 0. After `idx`=7, go to STOP. Sampling therefore lands at mid-bit.
- **STOP:** when `cnt`=CLKS_PER_BIT-1, sample `rx_s`.
  - `rx_s`=1: push `shreg` and go to IDLE.
  - `rx_s`=0: set `frame_err`, discard the byte, and go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. A break condition therefore produces exactly one error.
- **Push rules:**
  - FIFO not full: write the byte.
  - FIFO full, no pop in the same cycle: discard the byte and set `overrun`. Stored data is unchanged.
  - FIFO full, pop in the same cycle: the pop frees a slot and the push is accepted. `count` is unchanged and `overrun` stays clear.
- **FIFO structure:** circular buffer with read/write pointers that wrap modulo DEPTH. `count` is updated as +1 on push only, −1 on pop only, and unchanged on both or neither.
- **Error clearing:** `clr_err` has priority over a same-cycle set. That set is lost.
- **Reset (any time, including mid-frame):** FSM → IDLE. `cnt`, `idx`, `shreg`, pointers and `count` → 0. `rd_valid`, `busy`, `frame_err`, `overrun` → 0, and `rd_data` → 0. A partially received frame is dropped. After reset, a line that is already low is taken as a start bit once it has passed through the synchroniser.

## Timing
- `RXD` falling edge → START entry: 2–3 cycles (synchroniser).
- Start-bit check occurs CLKS_PER_BIT/2 cycles after START entry.
- Each data sample follows the previous sample by CLKS_PER_BIT cycles.
- STOP sample (1) → `rd_valid`/`count` update: on the next edge, i.e. 1 cycle.
- `rd_en`: `rd_data` shows the next entry and `count` decrements 1 cycle after the edge on which `rd_en`=1.
- Tolerance: a start bit stretched by up to CLKS_PER_BIT/2 − 1 cycles still samples correctly. The bench's +10-cycle start stretch must pass.
- Minimum frame-to-frame gap: the next start may begin in the cycle after the STOP sample.

## Test plan
- **Single frame:** send 0x35 at 215 clk/bit with the start bit stretched +10 clk → `rd_valid`=1, `rd_data`=0x35, `count`=1, no flags; `rd_en` pulse → `count`=0, `rd_valid`=0.
- **Fill and overrun:** send 0x35, 0x37, 0x38, 0x0A with no reads → `count`=4, entries popped in that order. Then send 0x31 while full → `overrun`=1, `count`=4, contents still 0x35..0x0A. `clr_err` → `overrun`=0.
- **Glitch and framing error:**
  - `RXD` low for 50 clk, then high → FSM returns to IDLE, `count` unchanged, no flags.
  - Frame 0x55 with stop bit 0 and line held low for 3 bit times → `frame_err`=1, nothing pushed, `busy` stays 1 until the line goes high.
- **Full + simultaneous pop:** FIFO full, assert `rd_en` on the exact cycle the 5th byte (0x34) completes → `overrun`=0, `count`=4, newest entry is 0x34.
- **Reset mid-frame:** assert `resetn`=0 during bit 4 of 0xA5 → all outputs 0 immediately. Release, then send 0x0A → only 0x0A is received.
- **Wrap-around:** send and read 10 bytes 0x00..0x09 one at a time, so the pointers wrap twice → every byte is read in order and `count` is never more than 1.
